// File: rtl/rxd_pkg.sv
// Shared types and default address map for the instruction-bus interconnect.
// ID_ERR and instr_bus_id_t match the default two-slave configuration.
package rxd_pkg;

    localparam logic [31:0] BOOT_ROM_ADDRESS_SPACE = 32'h0000_1000;
    localparam logic [31:0] CODE_RAM_ADDRESS_SPACE = 32'h0001_0000;
    localparam logic [31:0] BOOT_ROM_BASE          = 32'h0000_0000;
    localparam logic [31:0] CODE_RAM_BASE          = 32'h0001_0000;

    localparam int INSTR_BUS_N_SLAVES = 2;
    localparam int INSTR_BUS_ID_W     = $clog2(INSTR_BUS_N_SLAVES + 1);

    typedef logic [INSTR_BUS_ID_W-1:0] instr_bus_id_t;

    // The ID one past the last slave marks a fetch that is answered internally.
    localparam instr_bus_id_t ID_ERR = instr_bus_id_t'(INSTR_BUS_N_SLAVES);

    localparam logic [31:0] INSTR_BUS_BASE_DEFAULT [INSTR_BUS_N_SLAVES] =
        '{BOOT_ROM_BASE, CODE_RAM_BASE};
    localparam logic [31:0] INSTR_BUS_MASK_DEFAULT [INSTR_BUS_N_SLAVES] =
        '{~(BOOT_ROM_ADDRESS_SPACE - 32'd1), ~(CODE_RAM_ADDRESS_SPACE - 32'd1)};

    function automatic logic addr_hit(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [31:0] mask);
        return (addr & mask) == base;
    endfunction

endpackage

// File: rtl/instr_bus_router_if.sv
// Fetch-side and slave-side signals of the instruction-bus router.
// The master modport is the router's own view; slave is the environment's view.
interface instr_bus_router_if #(parameter int N_SLAVES = 2);

    logic                     m_req;
    logic [31:0]              m_addr;
    logic                     m_gnt;
    logic                     m_rvalid;
    logic [31:0]              m_rdata;
    logic                     m_err;
    logic [N_SLAVES-1:0]      s_req;
    logic [31:0]              s_addr;
    logic [N_SLAVES-1:0]      s_gnt;
    logic [N_SLAVES-1:0]      s_rvalid;
    logic [N_SLAVES-1:0][31:0] s_rdata;

    modport master (
        input  m_req, m_addr, s_gnt, s_rvalid, s_rdata,
        output m_gnt, m_rvalid, m_rdata, m_err, s_req, s_addr
    );

    modport slave (
        output m_req, m_addr, s_gnt, s_rvalid, s_rdata,
        input  m_gnt, m_rvalid, m_rdata, m_err, s_req, s_addr
    );

endinterface

// File: rtl/instr_bus_id_fifo.sv
// In-order FIFO of target IDs for granted fetches awaiting their response.
// Head is read combinationally; there is no fall-through from push to head.
module instr_bus_id_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is not reset; count and pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/instr_bus_router.sv
// Instruction-bus interconnect: decodes fetches onto N_SLAVES slaves, tracks
// outstanding fetches in order and returns responses (or errors) to the core.
module instr_bus_router
    import rxd_pkg::*;
#(
    parameter int          N_SLAVES              = 2,
    parameter int          DEPTH                 = 2,
    parameter logic [31:0] SLAVE_BASE [N_SLAVES] = INSTR_BUS_BASE_DEFAULT,
    parameter logic [31:0] SLAVE_MASK [N_SLAVES] = INSTR_BUS_MASK_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    instr_bus_router_if.master bus,
    output logic               protocol_err
);

    localparam int ID_W = $clog2(N_SLAVES + 1);
    typedef logic [ID_W-1:0] id_t;
    localparam id_t TGT_ERR = id_t'(N_SLAVES);

    id_t  tgt, head;
    logic ok, push, pop, full, empty, unexpected;

    assign ok         = bus.m_req && !full;
    assign push       = bus.m_gnt;
    assign bus.s_addr = bus.m_addr;

    // NOTE: every signal written here gets a default first, so no latches appear.
    always_comb begin
        tgt       = TGT_ERR;
        bus.s_req = '0;
        bus.m_gnt = 1'b0;
        // Walk downwards so the lowest-index hit is the one left standing.
        for (int i = N_SLAVES - 1; i >= 0; i--) begin
            if (addr_hit(bus.m_addr, SLAVE_BASE[i], SLAVE_MASK[i])) tgt = id_t'(i);
        end
        if (tgt == TGT_ERR) begin
            bus.m_gnt = ok;
        end else begin
            for (int i = 0; i < N_SLAVES; i++) begin
                if (tgt == id_t'(i)) begin
                    bus.s_req[i] = ok;
                    bus.m_gnt    = ok && bus.s_gnt[i];
                end
            end
        end
    end

    always_comb begin
        pop          = 1'b0;
        bus.m_rvalid = 1'b0;
        bus.m_err    = 1'b0;
        bus.m_rdata  = '0;
        unexpected   = 1'b0;
        if (!empty && head == TGT_ERR) begin
            pop          = 1'b1;
            bus.m_rvalid = 1'b1;
            bus.m_err    = 1'b1;
        end
        for (int j = 0; j < N_SLAVES; j++) begin
            if (bus.s_rvalid[j]) begin
                if (!empty && head == id_t'(j)) begin
                    pop          = 1'b1;
                    bus.m_rvalid = 1'b1;
                    bus.m_rdata  = bus.s_rdata[j];
                end else begin
                    unexpected = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)             protocol_err <= 1'b0;
        else if (unexpected) protocol_err <= 1'b1;
    end

    instr_bus_id_fifo #(
        .WIDTH (ID_W),
        .DEPTH (DEPTH)
    ) u_id_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (tgt),
        .pop   (pop),
        .head  (head),
        .full  (full),
        .empty (empty)
    );

endmodule

// File: tb/tb_instr_bus_router.sv
// Directed bench for instr_bus_router in its default two-slave, DEPTH=2 setup.
// Inputs change 1 ns after the rising edge; outputs are sampled mid-cycle.
module tb_instr_bus_router;

    logic clk = 1'b0;
    logic rst;
    logic protocol_err;
    int   n_cmp = 0;
    int   n_bad = 0;

    localparam logic [31:0] ROM_A   = 32'h0000_0010;
    localparam logic [31:0] ROM_B   = 32'h0000_0020;
    localparam logic [31:0] RAM_A   = 32'h0001_0004;
    localparam logic [31:0] UNMAPPD = 32'h8000_0000;

    always #5 clk = ~clk;

    instr_bus_router_if #(.N_SLAVES(2)) bus ();

    instr_bus_router #(
        .N_SLAVES (2),
        .DEPTH    (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .protocol_err (protocol_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One bus cycle: apply inputs just after the edge, leave time to settle.
    task automatic drive(input logic req, input logic [31:0] addr,
                         input logic [1:0] gnt, input logic [1:0] rv,
                         input logic [31:0] rd0, input logic [31:0] rd1);
        @(posedge clk);
        #1;
        bus.m_req      = req;
        bus.m_addr     = addr;
        bus.s_gnt      = gnt;
        bus.s_rvalid   = rv;
        bus.s_rdata[0] = rd0;
        bus.s_rdata[1] = rd1;
        #4;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 2'b00, 2'b00, 32'h0, 32'h0);
    endtask

    initial begin
        rst            = 1'b1;
        bus.m_req      = 1'b0;
        bus.m_addr     = '0;
        bus.s_gnt      = '0;
        bus.s_rvalid   = '0;
        bus.s_rdata    = '0;
        idle();
        idle();
        check("rst_m_gnt",    {31'h0, bus.m_gnt},    32'h0);
        check("rst_m_rvalid", {31'h0, bus.m_rvalid}, 32'h0);
        check("rst_s_req",    {30'h0, bus.s_req},    32'h0);
        check("rst_perr",     {31'h0, protocol_err}, 32'h0);
        rst = 1'b0;

        // Boot ROM fetch, response one cycle later
        drive(1'b1, ROM_A, 2'b01, 2'b00, 32'h0, 32'h0);
        check("t1_s_req",  {30'h0, bus.s_req}, 32'h1);
        check("t1_m_gnt",  {31'h0, bus.m_gnt}, 32'h1);
        check("t1_s_addr", bus.s_addr, ROM_A);
        drive(1'b0, 32'h0, 2'b00, 2'b01, 32'h1234_5678, 32'h0);
        check("t1_rvalid", {31'h0, bus.m_rvalid}, 32'h1);
        check("t1_rdata",  bus.m_rdata, 32'h1234_5678);
        check("t1_err",    {31'h0, bus.m_err}, 32'h0);
        idle();
        check("t1_idle_rvalid", {31'h0, bus.m_rvalid}, 32'h0);
        check("t1_idle_rdata",  bus.m_rdata, 32'h0);

        // Back-to-back ROM then RAM, responses in order
        drive(1'b1, ROM_B, 2'b11, 2'b00, 32'h0, 32'h0);
        check("t2_gnt0", {31'h0, bus.m_gnt}, 32'h1);
        drive(1'b1, RAM_A, 2'b11, 2'b00, 32'h0, 32'h0);
        check("t2_s_req1", {30'h0, bus.s_req}, 32'h2);
        check("t2_gnt1",   {31'h0, bus.m_gnt}, 32'h1);
        drive(1'b0, 32'h0, 2'b00, 2'b01, 32'hAAAA_0001, 32'h0);
        check("t2_rvalid0", {31'h0, bus.m_rvalid}, 32'h1);
        check("t2_rdata0",  bus.m_rdata, 32'hAAAA_0001);
        drive(1'b0, 32'h0, 2'b00, 2'b10, 32'h0, 32'hBBBB_0002);
        check("t2_rvalid1", {31'h0, bus.m_rvalid}, 32'h1);
        check("t2_rdata1",  bus.m_rdata, 32'hBBBB_0002);
        idle();
        check("t2_perr", {31'h0, protocol_err}, 32'h0);

        // Unmapped fetch answered internally with an error
        drive(1'b1, UNMAPPD, 2'b00, 2'b00, 32'h0, 32'h0);
        check("t3_gnt",   {31'h0, bus.m_gnt}, 32'h1);
        check("t3_s_req", {30'h0, bus.s_req}, 32'h0);
        check("t3_no_rsp_same_cycle", {31'h0, bus.m_rvalid}, 32'h0);
        idle();
        check("t3_rvalid", {31'h0, bus.m_rvalid}, 32'h1);
        check("t3_err",    {31'h0, bus.m_err},    32'h1);
        check("t3_rdata",  bus.m_rdata, 32'h0);
        idle();
        check("t3_popped", {31'h0, bus.m_rvalid}, 32'h0);

        // FIFO full: third request blocked, even in the cycle a pop happens
        drive(1'b1, ROM_A, 2'b01, 2'b00, 32'h0, 32'h0);
        check("t4_gnt0", {31'h0, bus.m_gnt}, 32'h1);
        drive(1'b1, ROM_A, 2'b01, 2'b00, 32'h0, 32'h0);
        check("t4_gnt1", {31'h0, bus.m_gnt}, 32'h1);
        drive(1'b1, ROM_A, 2'b01, 2'b00, 32'h0, 32'h0);
        check("t4_full_gnt",   {31'h0, bus.m_gnt}, 32'h0);
        check("t4_full_s_req", {30'h0, bus.s_req}, 32'h0);
        drive(1'b1, ROM_A, 2'b01, 2'b01, 32'hC0DE_0001, 32'h0);
        check("t4_pop_rvalid", {31'h0, bus.m_rvalid}, 32'h1);
        check("t4_pop_nogrant", {31'h0, bus.m_gnt}, 32'h0);
        drive(1'b1, ROM_A, 2'b01, 2'b00, 32'h0, 32'h0);
        check("t4_regrant", {31'h0, bus.m_gnt}, 32'h1);
        drive(1'b0, 32'h0, 2'b00, 2'b01, 32'hC0DE_0002, 32'h0);
        check("t4_drain0", bus.m_rdata, 32'hC0DE_0002);
        drive(1'b0, 32'h0, 2'b00, 2'b01, 32'hC0DE_0003, 32'h0);
        check("t4_drain1", bus.m_rdata, 32'hC0DE_0003);
        drive(1'b0, 32'h0, 2'b00, 2'b01, 32'hC0DE_0004, 32'h0);
        check("t4_empty_rvalid", {31'h0, bus.m_rvalid}, 32'h0);
        idle();
        check("t4_spurious_perr", {31'h0, protocol_err}, 32'h1);

        // Out-of-order response: RAM answers while ROM is at the head
        drive(1'b1, ROM_A, 2'b01, 2'b00, 32'h0, 32'h0);
        check("t5_gnt", {31'h0, bus.m_gnt}, 32'h1);
        drive(1'b0, 32'h0, 2'b00, 2'b10, 32'h0, 32'hDEAD_BEEF);
        check("t5_ooo_rvalid", {31'h0, bus.m_rvalid}, 32'h0);
        drive(1'b0, 32'h0, 2'b00, 2'b01, 32'h5555_AAAA, 32'h0);
        check("t5_perr",   {31'h0, protocol_err}, 32'h1);
        check("t5_rdata",  bus.m_rdata, 32'h5555_AAAA);
        idle();
        check("t5_perr_sticky", {31'h0, protocol_err}, 32'h1);

        // Reset with two fetches outstanding
        drive(1'b1, ROM_A, 2'b01, 2'b00, 32'h0, 32'h0);
        drive(1'b1, ROM_B, 2'b01, 2'b00, 32'h0, 32'h0);
        check("t6_gnt1", {31'h0, bus.m_gnt}, 32'h1);
        rst = 1'b1;
        idle();
        check("t6_rst_perr",   {31'h0, protocol_err}, 32'h0);
        check("t6_rst_rvalid", {31'h0, bus.m_rvalid}, 32'h0);
        check("t6_rst_rdata",  bus.m_rdata, 32'h0);
        check("t6_rst_err",    {31'h0, bus.m_err}, 32'h0);
        rst = 1'b0;
        drive(1'b1, ROM_A, 2'b01, 2'b00, 32'h0, 32'h0);
        check("t6_fresh_gnt", {31'h0, bus.m_gnt}, 32'h1);
        drive(1'b0, 32'h0, 2'b00, 2'b01, 32'h0BAD_F00D, 32'h0);
        check("t6_fresh_rdata", bus.m_rdata, 32'h0BAD_F00D);
        drive(1'b0, 32'h0, 2'b00, 2'b01, 32'h1111_2222, 32'h0);
        check("t6_flushed", {31'h0, bus.m_rvalid}, 32'h0);
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
